// File: rtl/driver_pattern_stage.sv
// Pattern-memory driver stage: reads row/col pattern words, selects one bit per driver
// and drives break-before-make high/low pairs with a programmable dead time.
module driver_pattern_stage #(
  parameter int MEM_ADDRESS_LENGTH = 7,
  parameter int NUM_OF_DRIVERS     = 16,
  parameter int DEAD_TIME          = 2
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          mem_write_n,
  input  logic [MEM_ADDRESS_LENGTH:0]   mem_address,
  input  logic [NUM_OF_DRIVERS-1:0]     mem_data,
  input  logic [MEM_ADDRESS_LENGTH-1:0] row_select,
  input  logic [MEM_ADDRESS_LENGTH-1:0] col_select,
  input  logic                          output_active,
  input  logic [NUM_OF_DRIVERS-1:0]     inverter_select,
  input  logic [NUM_OF_DRIVERS-1:0]     row_col_select,
  input  logic                          estop,
  output logic [NUM_OF_DRIVERS-1:0]     driver_high,
  output logic [NUM_OF_DRIVERS-1:0]     driver_low,
  output logic [NUM_OF_DRIVERS-1:0]     dead_active
);

  localparam int         DEPTH       = 2 ** MEM_ADDRESS_LENGTH;
  localparam logic [7:0] DEAD_RELOAD = 8'(DEAD_TIME - 1);

  typedef enum logic [1:0] {ST_OFF, ST_HIGH, ST_LOW, ST_DEAD} drv_state_t;

  logic [NUM_OF_DRIVERS-1:0]     row_mem [DEPTH];
  logic [NUM_OF_DRIVERS-1:0]     col_mem [DEPTH];
  logic [MEM_ADDRESS_LENGTH-1:0] word_index;
  logic                          bank_sel;

  logic [NUM_OF_DRIVERS-1:0] row_word;
  logic [NUM_OF_DRIVERS-1:0] col_word;
  logic                      active_q;
  logic [NUM_OF_DRIVERS-1:0] invert_q;
  logic [NUM_OF_DRIVERS-1:0] source_q;
  logic [NUM_OF_DRIVERS-1:0] pick_bit;

  drv_state_t state      [NUM_OF_DRIVERS];
  drv_state_t state_next [NUM_OF_DRIVERS];
  drv_state_t desired    [NUM_OF_DRIVERS];
  logic [7:0] dead_cnt      [NUM_OF_DRIVERS];
  logic [7:0] dead_cnt_next [NUM_OF_DRIVERS];

  assign word_index = mem_address[MEM_ADDRESS_LENGTH-1:0];
  assign bank_sel   = mem_address[MEM_ADDRESS_LENGTH];

  // Pattern banks are deliberately not reset; contents persist across reset_n.
  always_ff @(posedge clock) begin
    if (!mem_write_n) begin
      if (bank_sel) col_mem[word_index] <= mem_data;
      else          row_mem[word_index] <= mem_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      row_word <= '0;
      col_word <= '0;
      active_q <= 1'b0;
      invert_q <= '0;
      source_q <= '0;
    end else begin
      row_word <= row_mem[row_select];
      col_word <= col_mem[col_select];
      active_q <= output_active;
      invert_q <= inverter_select;
      source_q <= row_col_select;
    end
  end

  assign pick_bit = ((source_q & col_word) | (~source_q & row_word)) ^ invert_q;

  always_comb begin
    for (int i = 0; i < NUM_OF_DRIVERS; i++) begin
      desired[i] = ST_OFF;
      if (active_q) desired[i] = pick_bit[i] ? ST_HIGH : ST_LOW;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_OF_DRIVERS; i++) begin
        state[i]    <= ST_OFF;
        dead_cnt[i] <= 8'd0;
      end
    end else begin
      for (int i = 0; i < NUM_OF_DRIVERS; i++) begin
        state[i]    <= state_next[i];
        dead_cnt[i] <= dead_cnt_next[i];
      end
    end
  end

  // estop outranks the desired state: it can push drivers into DEAD but never out of it.
  always_comb begin
    for (int i = 0; i < NUM_OF_DRIVERS; i++) begin
      state_next[i]    = state[i];
      dead_cnt_next[i] = dead_cnt[i];
      case (state[i])
        ST_OFF: begin
          if (!estop && desired[i] != ST_OFF) state_next[i] = desired[i];
        end
        ST_HIGH, ST_LOW: begin
          if (estop || desired[i] != state[i]) begin
            state_next[i]    = ST_DEAD;
            dead_cnt_next[i] = DEAD_RELOAD;
          end
        end
        ST_DEAD: begin
          if (estop)                    dead_cnt_next[i] = DEAD_RELOAD;
          else if (dead_cnt[i] != 8'd0) dead_cnt_next[i] = dead_cnt[i] - 8'd1;
          else                          state_next[i]    = desired[i];
        end
        default: state_next[i] = ST_OFF;
      endcase
    end
  end

  always_comb begin
    driver_high = '0;
    driver_low  = '0;
    dead_active = '0;
    for (int i = 0; i < NUM_OF_DRIVERS; i++) begin
      driver_high[i] = (state[i] == ST_HIGH);
      driver_low[i]  = (state[i] == ST_LOW);
      dead_active[i] = (state[i] == ST_DEAD);
    end
  end

endmodule

// File: tb/tb_driver_pattern_stage.sv
// Directed self-checking bench for driver_pattern_stage: table-driven steady-state
// vectors plus hand-written dead-time, estop, read-during-write and reset sequences.
module tb_driver_pattern_stage;

  logic        clock;
  logic        reset_n;
  logic        mem_write_n;
  logic [7:0]  mem_address;
  logic [15:0] mem_data;
  logic [6:0]  row_select;
  logic [6:0]  col_select;
  logic        output_active;
  logic [15:0] inverter_select;
  logic [15:0] row_col_select;
  logic        estop;
  logic [15:0] driver_high;
  logic [15:0] driver_low;
  logic [15:0] dead_active;

  int total_checks;
  int passed_checks;

  typedef struct {
    logic [6:0]  rs;
    logic [6:0]  cs;
    logic        oa;
    logic [15:0] inv;
    logic [15:0] rcs;
    logic [15:0] exp_high;
    logic [15:0] exp_low;
  } vec_t;

  vec_t vecs[6];

  driver_pattern_stage #(
    .MEM_ADDRESS_LENGTH(7),
    .NUM_OF_DRIVERS(16),
    .DEAD_TIME(2)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .mem_write_n(mem_write_n),
    .mem_address(mem_address),
    .mem_data(mem_data),
    .row_select(row_select),
    .col_select(col_select),
    .output_active(output_active),
    .inverter_select(inverter_select),
    .row_col_select(row_col_select),
    .estop(estop),
    .driver_high(driver_high),
    .driver_low(driver_low),
    .dead_active(dead_active)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total_checks++;
    if (act === exp) passed_checks++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_out(input string name, input logic [15:0] eh, input logic [15:0] el,
                           input logic [15:0] ed);
    check({name, ".high"}, driver_high, eh);
    check({name, ".low"},  driver_low,  el);
    check({name, ".dead"}, dead_active, ed);
  endtask

  // Advance one edge and sample 1 time unit later; shoot-through is checked every cycle.
  task automatic tick();
    @(posedge clock);
    #1;
    check("no_overlap", driver_high & driver_low, 16'h0000);
  endtask

  task automatic mem_write(input logic bank, input logic [6:0] idx, input logic [15:0] data);
    mem_write_n = 1'b0;
    mem_address = {bank, idx};
    mem_data    = data;
    tick();
    mem_write_n = 1'b1;
  endtask

  task automatic set_inputs(input logic [6:0] rs, input logic [6:0] cs, input logic oa,
                            input logic [15:0] inv, input logic [15:0] rcs);
    row_select      = rs;
    col_select      = cs;
    output_active   = oa;
    inverter_select = inv;
    row_col_select  = rcs;
  endtask

  initial begin
    total_checks    = 0;
    passed_checks   = 0;
    reset_n         = 1'b0;
    mem_write_n     = 1'b1;
    mem_address     = '0;
    mem_data        = '0;
    estop           = 1'b0;
    set_inputs(7'd0, 7'd0, 1'b0, 16'h0000, 16'h0000);

    vecs[0] = '{rs: 7'd10, cs: 7'd10, oa: 1'b1, inv: 16'h0000, rcs: 16'h0000, exp_high: 16'hAAAA, exp_low: 16'h5555};
    vecs[1] = '{rs: 7'd10, cs: 7'd10, oa: 1'b1, inv: 16'h0000, rcs: 16'hFFFF, exp_high: 16'h1234, exp_low: 16'hEDCB};
    vecs[2] = '{rs: 7'd10, cs: 7'd10, oa: 1'b1, inv: 16'hFFFF, rcs: 16'h0000, exp_high: 16'h5555, exp_low: 16'hAAAA};
    vecs[3] = '{rs: 7'd3,  cs: 7'd10, oa: 1'b1, inv: 16'h00F0, rcs: 16'hFF00, exp_high: 16'h120F, exp_low: 16'hEDF0};
    vecs[4] = '{rs: 7'd3,  cs: 7'd10, oa: 1'b0, inv: 16'h00F0, rcs: 16'hFF00, exp_high: 16'h0000, exp_low: 16'h0000};
    vecs[5] = '{rs: 7'd3,  cs: 7'd5,  oa: 1'b1, inv: 16'h0000, rcs: 16'hF0F0, exp_high: 16'h000F, exp_low: 16'hFFF0};

    #12;
    check_out("reset", 16'h0000, 16'h0000, 16'h0000);
    reset_n = 1'b1;
    tick();

    mem_write(1'b0, 7'd3,  16'h00FF);
    mem_write(1'b1, 7'd5,  16'h0F0F);
    mem_write(1'b0, 7'd10, 16'hAAAA);
    mem_write(1'b1, 7'd10, 16'h1234);
    check_out("idle_after_writes", 16'h0000, 16'h0000, 16'h0000);

    // Two-cycle latency from OFF, no dead time.
    set_inputs(7'd3, 7'd5, 1'b1, 16'h0000, 16'h0000);
    tick();
    check_out("latency_e1", 16'h0000, 16'h0000, 16'h0000);
    tick();
    check_out("latency_e2", 16'h00FF, 16'hFF00, 16'h0000);

    // Switch all drivers to the column word: drivers 4..11 flip through DEAD.
    row_col_select = 16'hFFFF;
    tick();
    check_out("colsw_e1", 16'h00FF, 16'hFF00, 16'h0000);
    tick();
    check_out("colsw_dead1", 16'h000F, 16'hF000, 16'h0FF0);
    tick();
    check_out("colsw_dead2", 16'h000F, 16'hF000, 16'h0FF0);
    tick();
    check_out("colsw_settle", 16'h0F0F, 16'hF0F0, 16'h0000);

    // Invert driver 0 while HIGH.
    inverter_select = 16'h0001;
    tick();
    check_out("inv_e1", 16'h0F0F, 16'hF0F0, 16'h0000);
    tick();
    check_out("inv_dead1", 16'h0F0E, 16'hF0F0, 16'h0001);
    tick();
    check_out("inv_dead2", 16'h0F0E, 16'hF0F0, 16'h0001);
    tick();
    check_out("inv_settle", 16'h0F0E, 16'hF0F1, 16'h0000);

    // Single-cycle estop.
    estop = 1'b1;
    tick();
    check_out("estop1_dead", 16'h0000, 16'h0000, 16'hFFFF);
    estop = 1'b0;
    tick();
    check_out("estop1_dead2", 16'h0000, 16'h0000, 16'hFFFF);
    tick();
    check_out("estop1_back", 16'h0F0E, 16'hF0F1, 16'h0000);

    // Five-cycle estop keeps everything in DEAD, then DEAD_TIME more cycles.
    estop = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_out($sformatf("estop5_hold%0d", i), 16'h0000, 16'h0000, 16'hFFFF);
    end
    estop = 1'b0;
    tick();
    check_out("estop5_tail", 16'h0000, 16'h0000, 16'hFFFF);
    tick();
    check_out("estop5_back", 16'h0F0E, 16'hF0F1, 16'h0000);

    for (int v = 0; v < 6; v++) begin
      set_inputs(vecs[v].rs, vecs[v].cs, vecs[v].oa, vecs[v].inv, vecs[v].rcs);
      for (int c = 0; c < 5; c++) tick();
      check_out($sformatf("vec%0d", v), vecs[v].exp_high, vecs[v].exp_low, 16'h0000);
    end

    // Read-during-write to the word being read returns the old data.
    set_inputs(7'd3, 7'd5, 1'b1, 16'h0000, 16'h0000);
    for (int c = 0; c < 5; c++) tick();
    check_out("rdw_before", 16'h00FF, 16'hFF00, 16'h0000);
    mem_write(1'b0, 7'd3, 16'hFF00);
    check_out("rdw_w", 16'h00FF, 16'hFF00, 16'h0000);
    tick();
    check_out("rdw_w1", 16'h00FF, 16'hFF00, 16'h0000);
    tick();
    check_out("rdw_w2_dead", 16'h0000, 16'h0000, 16'hFFFF);
    tick();
    tick();
    check_out("rdw_new", 16'hFF00, 16'h00FF, 16'h0000);

    // Drop output_active, then reset asynchronously while in DEAD.
    output_active = 1'b0;
    tick();
    check_out("oa_off_e1", 16'hFF00, 16'h00FF, 16'h0000);
    tick();
    check_out("oa_off_dead", 16'h0000, 16'h0000, 16'hFFFF);
    #2;
    reset_n = 1'b0;
    #1;
    check_out("async_reset", 16'h0000, 16'h0000, 16'h0000);
    #1;
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_out($sformatf("post_reset%0d", c), 16'h0000, 16'h0000, 16'h0000);
    end

    // Memory survives reset.
    output_active = 1'b1;
    tick();
    tick();
    check_out("mem_retained", 16'hFF00, 16'h00FF, 16'h0000);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule

// File: doc/driver_pattern_stage.md
Name: driver_pattern_stage

Overview:
- Downstream of the backend cycle controller; holds the row and column pattern memories.
- Reads the pattern words addressed by row_select/col_select and picks a row or column bit per driver, with optional inversion.
- Gates the result with output_active and drives a high-side/low-side pair per motor driver.
- Each high↔low polarity change passes through a break-before-make dead-time interval.

Parameters:
- MEM_ADDRESS_LENGTH, 7, width of row/col address; each bank holds 2**MEM_ADDRESS_LENGTH words.
- NUM_OF_DRIVERS, 16, number of driver channels; also the pattern word width.
- DEAD_TIME, 2, cycles both outputs stay low between opposite polarities; legal range 1..255.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- mem_write_n  in  1  active-low pattern memory write strobe, sampled on clock.
- mem_address  in  MEM_ADDRESS_LENGTH+1  bit[MSB]=0 selects the row bank, 1 selects the col bank; low bits are the word index.
- mem_data  in  NUM_OF_DRIVERS  pattern word to write.
- row_select  in  MEM_ADDRESS_LENGTH  row bank read index, from the cycle controller.
- col_select  in  MEM_ADDRESS_LENGTH  col bank read index, from the cycle controller.
- output_active  in  1  drive window from the cycle controller.
- inverter_select  in  NUM_OF_DRIVERS  per-driver polarity invert.
- row_col_select  in  NUM_OF_DRIVERS  per-driver source: 0 = row word bit, 1 = col word bit.
- estop  in  1  synchronous emergency stop, active high.
- driver_high  out  NUM_OF_DRIVERS  high-side enable per driver.
- driver_low  out  NUM_OF_DRIVERS  low-side enable per driver.
- dead_active  out  NUM_OF_DRIVERS  1 while the driver is in DEAD state.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - Clears pipeline registers, driver states (to OFF) and dead counters.
  - driver_high, driver_low and dead_active are all 0.
  - Memory contents are not reset; they are undefined until written.
- Memory write: at an edge with mem_write_n=0, the bank/word given by mem_address takes mem_data.
- Read-during-write to the same word returns the old data.
- Stage 1, edge E1:
  - Registers row_word=rowmem[row_select] and col_word=colmem[col_select].
  - Also registers output_active, inverter_select and row_col_select so all four are aligned.
- Desired state per driver i, computed combinationally from stage-1 registers:
  - bit = (row_col_select_q[i] ? col_word[i] : row_word[i]) ^ inverter_select_q[i].
  - desired = OFF if output_active_q=0, else HIGH if bit=1, else LOW.
- Driver FSM per driver, updated at edge E2. States OFF, HIGH, LOW, DEAD, with a dead counter of 8 bits.
  - OFF: desired HIGH→HIGH; desired LOW→LOW; otherwise stay.
  - HIGH/LOW: desired equals current→stay; any other desired (including OFF)→DEAD, counter=DEAD_TIME-1.
  - DEAD: counter>0→decrement and stay; counter=0→go to desired (OFF, HIGH or LOW).
  - DEAD therefore lasts exactly DEAD_TIME cycles.
  - estop=1 at an edge:
    - HIGH/LOW→DEAD with counter reload.
    - DEAD reloads its counter.
    - OFF stays OFF.
    - No driver leaves DEAD/OFF to an active state while estop=1.
- Outputs are registered state decodes, with no combinational path from inputs:
  - HIGH→high=1, low=0.
  - LOW→high=0, low=1.
  - OFF/DEAD→both 0.
  - driver_high[i]&driver_low[i] is never 1.
- Latency: from row_select/col_select/output_active at edge E0 setup, the outputs change after the second following edge (2 cycles) when no dead time applies.
- With dead time, the opposite polarity appears 2+DEAD_TIME cycles after the input change.
- Simultaneous events:
  - estop has priority over desired state.
  - A write to the currently-read word affects the output only from the next read.
- Reset mid-DEAD returns the driver to OFF immediately, with outputs 0 asynchronously.

Test Plan:
- Write rowmem[3]=16'h00FF and colmem[5]=16'h0F0F. Apply row_select=3, col_select=5, row_col_select=0, inverter_select=0, output_active=1 → after 2 edges driver_high=16'h00FF, driver_low=16'hFF00.
- From the previous state, set row_col_select=16'hFFFF (DEAD_TIME=2):
  - Drivers 4-7 and 8-11 both go to 00 with dead_active=1 for exactly 2 cycles.
  - They then settle to high=16'h0F0F, low=16'hF0F0.
  - Unchanged drivers never glitch.
- Set inverter_select=16'h0001 while driver 0 is HIGH → driver 0 goes DEAD for 2 cycles, then LOW; high&low is never 1 on any cycle.
- Drop output_active to 0 with all drivers active → all enter DEAD for 2 cycles, then OFF; outputs 0 throughout.
- Assert estop for 1 cycle during steady HIGH → driver goes DEAD. Hold estop 5 cycles → it stays DEAD, then returns to HIGH DEAD_TIME cycles after estop falls.
- Assert reset_n=0 asynchronously mid-DEAD → outputs and dead_active are 0 immediately. After release with output_active=0 they stay 0, and memory contents are retained.
